// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encodings and width helper for the vector MAC
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/smul_w.sv
// rtl/smul_w.sv - combinational W x W signed multiplier with full 2W-bit product
module smul_w #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mac_vec_sat.sv
// rtl/mac_vec_sat.sv - sequential signed dot-product engine with saturate/wrap result stage
module mac_vec_sat
    import mac_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sat_mode,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic           overflow
);

    localparam int ACC_W = 2*W + clog2(N);
    localparam int IW    = (N > 1) ? clog2(N) : 1;

    state_t                  state;
    state_t                  state_next;
    logic signed [W-1:0]     a_q [N];
    logic signed [W-1:0]     b_q [N];
    logic                    sat_q;
    logic [IW-1:0]           idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [2*W-1:0]   prod;
    logic                    accept;
    logic                    last;
    logic                    fin_ovf;
    logic [W-1:0]            fin_res;

    assign accept = start && (state != ST_RUN);
    assign last   = (idx == IW'(N-1));

    smul_w #(.W(W)) u_mul (
        .a (a_q[idx]),
        .b (b_q[idx]),
        .p (prod)
    );

    // The result stage looks at the sum including the final product so that
    // result/overflow land on the same edge that enters DONE.
    assign acc_next = acc + ACC_W'(prod);
    assign fin_ovf  = !((&acc_next[ACC_W-1:W-1]) || !(|acc_next[ACC_W-1:W-1]));

    always_comb begin
        fin_res = acc_next[W-1:0];
        if (sat_q && fin_ovf)
            fin_res = acc_next[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            sat_q    <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= in_a[W*i +: W];
                b_q[i] <= in_b[W*i +: W];
            end
            sat_q <= sat_mode;
            idx   <= '0;
            acc   <= '0;
        end else if (state == ST_RUN) begin
            acc <= acc_next;
            idx <= last ? '0 : idx + IW'(1);
            if (last) begin
                result   <= fin_res;
                overflow <= fin_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_vec_sat.sv
// tb/tb_mac_vec_sat.sv - directed self-checking bench for mac_vec_sat
module tb_mac_vec_sat;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sat_mode;
    logic [39:0] in_a, in_b;
    logic        busy, done, overflow;
    logic [7:0]  result;

    logic        start1, sat1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, ov1;
    logic [3:0]  result1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_vec_sat #(.W(8), .N(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_mode(sat_mode),
        .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
        .result(result), .overflow(overflow)
    );

    mac_vec_sat #(.W(4), .N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sat_mode(sat1),
        .in_a(a1), .in_b(b1), .busy(busy1), .done(done1),
        .result(result1), .overflow(ov1)
    );

    function automatic logic [39:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4);
        return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic do_op(input logic [39:0] a, input logic [39:0] b, input logic sat,
                         output int lat, output int bz);
        @(posedge clk); #1;
        in_a = a; in_b = b; sat_mode = sat; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bz  = int'(busy);
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bz += int'(busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; sat_mode = 0; in_a = '0; in_b = '0;
        start1 = 0; sat1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_result got=%h exp=00", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        total++; if ({result1, ov1, done1} !== 6'd0) begin bad++; $display("FAIL rst_small got=%b exp=0", {result1, ov1, done1}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bz;
        do_op(pk(1,2,3,4,5), pk(1,1,1,1,1), 1'b1, lat, bz);
        total++; if (lat != 6)         begin bad++; $display("FAIL t1_latency got=%0d exp=6", lat); end
        total++; if (bz != 5)          begin bad++; $display("FAIL t1_busy_cycles got=%0d exp=5", bz); end
        total++; if (result !== 8'd15) begin bad++; $display("FAIL t1_result got=%0d exp=15", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t1_ovf got=%b exp=0", overflow); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_saturate;
        int lat, bz;
        do_op(pk(127,127,127,127,127), pk(127,127,127,127,127), 1'b1, lat, bz);
        total++; if ({overflow, result} !== {1'b1, 8'h7f}) begin bad++; $display("FAIL t2_sat got=%b/%h exp=1/7f", overflow, result); end
        do_op(pk(127,127,127,127,127), pk(127,127,127,127,127), 1'b0, lat, bz);
        total++; if ({overflow, result} !== {1'b1, 8'h05}) begin bad++; $display("FAIL t2_wrap got=%b/%h exp=1/05", overflow, result); end
        do_op(pk(-128,-128,-128,-128,-128), pk(127,127,127,127,127), 1'b1, lat, bz);
        total++; if ({overflow, result} !== {1'b1, 8'h80}) begin bad++; $display("FAIL t3_negsat got=%b/%h exp=1/80", overflow, result); end
        do_op(pk(-128,-128,-128,-128,-128), pk(-128,-128,-128,-128,-128), 1'b1, lat, bz);
        total++; if ({overflow, result} !== {1'b1, 8'h7f}) begin bad++; $display("FAIL t3_minmin got=%b/%h exp=1/7f", overflow, result); end
    endtask

    task automatic test_mixed_ignore;
        int dones;
        logic [7:0] seen;
        seen = 8'h00;
        dones = 0;
        @(posedge clk); #1;
        in_a = pk(-3,7,-1,2,0); in_b = pk(4,-2,-5,6,9); sat_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_a = pk(1,2,3,4,5); in_b = pk(1,1,1,1,1); sat_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) begin dones++; seen = result; end
        end
        total++; if (dones != 1)       begin bad++; $display("FAIL t4_done_count got=%0d exp=1", dones); end
        total++; if (seen !== 8'hf7)   begin bad++; $display("FAIL t4_result got=%h exp=f7", seen); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t4_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid;
        int dones, lat, bz;
        dones = 0;
        @(posedge clk); #1;
        in_a = pk(1,2,3,4,5); in_b = pk(1,1,1,1,1); sat_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, overflow, result} !== 11'd0) begin bad++; $display("FAIL t5_abort got=%b exp=0", {busy, done, overflow, result}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL t5_no_done got=%0d exp=0", dones); end
        do_op(pk(1,2,3,4,5), pk(1,1,1,1,1), 1'b1, lat, bz);
        total++; if (lat != 6 || result !== 8'd15) begin bad++; $display("FAIL t5_restart got=%0d/%0d exp=6/15", lat, result); end
    endtask

    task automatic test_back_to_back;
        int k, cnt, lat;
        int d [3];
        cnt = 0;
        d[0] = 0; d[1] = 0; d[2] = 0;
        @(posedge clk); #1;
        in_a = pk(1,2,3,4,5); in_b = pk(1,1,1,1,1); sat_mode = 1'b1; start = 1'b1;
        for (k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (cnt < 3) d[cnt] = k;
                cnt++;
                total++; if (result !== 8'd15) begin bad++; $display("FAIL b2b_result got=%0d exp=15", result); end
                if (cnt == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        total++; if (cnt != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", cnt); end
        total++; if (d[0] != 6 || d[1] != 12 || d[2] != 18) begin bad++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=6,12,18", d[0], d[1], d[2]); end

        for (int s = 1; s >= 0; s--) begin
            @(posedge clk); #1;
            a1 = 4'd7; b1 = 4'd7; sat1 = s[0]; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            lat = 1;
            while (!done1 && lat < 20) begin @(posedge clk); #1; lat++; end
            total++; if (lat != 2) begin bad++; $display("FAIL n1_latency got=%0d exp=2", lat); end
            total++;
            if (s == 1 && {ov1, result1} !== {1'b1, 4'd7}) begin bad++; $display("FAIL n1_sat got=%b/%0d exp=1/7", ov1, result1); end
            else if (s == 0 && {ov1, result1} !== {1'b1, 4'd1}) begin bad++; $display("FAIL n1_wrap got=%b/%0d exp=1/1", ov1, result1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_mixed_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
